muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
// Iterative multiply/divide unit in the EX stage, beside the ALU; operand b is the
// register value or the extended immediate produced upstream. Performs MULT/MULTU/
// DIV/DIVU into architectural HI/LO over 33 cycles, and supports MTHI/MTLO writes.
// busy is exported to the hazard unit so MFHI/MFLO and new mul/div ops stall.
// PARAMETERS
// WIDTH  32  operand width; HI/LO each WIDTH bits; iteration count = WIDTH
// PORTS
// clk    in   1      rising-edge clock
// rstn   in   1      asynchronous, active-low reset
// start  in   1      launch op using a, b, op; accepted only when busy==0
// op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
// a      in   WIDTH  multiplicand / dividend (rs)
// b      in   WIDTH  multiplier / divisor (rt or extended immediate)
// mthi   in   1      write wdata to HI when idle
// mtlo   in   1      write wdata to LO when idle
// wdata  in   WIDTH  data for mthi/mtlo
// busy   out  1      operation in flight
// done   out  1      one-cycle pulse: HI/LO just updated by a mul/div
// hi     out  WIDTH  HI register
// lo     out  WIDTH  LO register
// BEHAVIOUR
// - Reset (rstn=0, any time, incl. mid-op): state=IDLE, busy=0, done=0, hi=0, lo=0,
//   counter=0, working registers 0; in-flight op discarded, no HI/LO write.
// - FSM: IDLE -> MUL (op 00/01) or DIV (op 10/11) on start&&!busy; MUL/DIV run
//   exactly WIDTH cycles (counter 0..WIDTH-1) -> FIX -> IDLE.
// - Timing: start sampled at edge E0; busy=1 after E0; HI/LO written at edge E33
//   (FIX), busy=0 and done=1 after E33; done clears after E34. Back-to-back start
//   accepted in the cycle done=1.
// - Signed ops: latch sign of a and b, operate on magnitudes (|-2^31| = 0x80000000
//   as unsigned); unsigned ops use raw values, signs forced 0.
// - MUL: shift-add, one multiplier bit per cycle, 2*WIDTH product. FIX: negate the
//   full 2*WIDTH product if sign_a^sign_b; {hi,lo} = product.
// - DIV: restoring, one quotient bit per cycle. FIX: quotient negated if
//   sign_a^sign_b, remainder negated if sign_a; lo=quotient, hi=remainder.
//   -2^31 / -1 (DIV) -> lo=0x80000000, hi=0 (natural wrap, no trap).
// - Divide by zero (b==0, detected at start): still WIDTH+1 cycles; result
//   hi=a (original, unmodified), lo={WIDTH{1'b1}}, for both DIV and DIVU.
// - mthi/mtlo: effective only when busy==0 and start==0; write at that edge, no
//   done pulse. Both asserted: both written. Ignored while busy.
// - start while busy: ignored, no effect on running op. start with op latched only
//   at acceptance; a/b/op may change freely afterwards.
// - start && mthi/mtlo same cycle while idle: start wins, move ignored.
// - hi/lo hold last value at all other times; outputs are registers only.
// TESTING
// 1 MULT a=7 b=6 -> busy 33 cycles, done pulse once, hi=0x00000000 lo=0x0000002A
// 2 MULT a=-3 b=5; MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFF lo=0xFFFFFFF1; then
//   hi=0xFFFFFFFE lo=0x00000001
// 3 DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU a=7 b=0 -> hi=7 lo=0xFFFFFFFF
// 4 DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0; DIVU 100/7 -> lo=14 hi=2
// 5 start+mthi(0x1234) pulsed at cycle 10 of a running MULT 7*6 -> both ignored,
//   final hi=0 lo=42; idle mtlo wdata=0xDEAD -> lo=0xDEAD next edge, done stays 0
// 6 rstn low at cycle 20 of DIVU 100/7 -> busy,done,hi,lo = 0 immediately (async);
//   after release, new MULTU 3*4 -> lo=12 in 33 cycles

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Bus between the EX-stage control and the iterative multiply/divide unit.
// The master launches ops and HI/LO moves; the slave reports busy/done and HI/LO.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO: WIDTH shift-add or restoring steps
// on operand magnitudes, then one fix-up cycle that applies signs and writes HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rstn,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic               busy_reg, done_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  // work holds {product high, multiplier} for MUL and {remainder, quotient} for DIV
  logic [2*WIDTH-1:0] work_reg;
  logic [WIDTH-1:0]   opb_reg, a_orig_reg;
  logic               sign_a_reg, sign_b_reg, is_div_reg, div_zero_reg;

  logic               idle, accept, sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign idle   = (state_reg == S_IDLE);
  assign accept = idle && bus.start;
  assign sgn_a  = !bus.op[0] && bus.a[WIDTH-1];
  assign sgn_b  = !bus.op[0] && bus.b[WIDTH-1];
  assign mag_a  = sgn_a ? -bus.a : bus.a;
  assign mag_b  = sgn_b ? -bus.b : bus.b;

  assign mul_sum  = {1'b0, work_reg[2*WIDTH-1:WIDTH]}
                  + {1'b0, (work_reg[0] ? opb_reg : {WIDTH{1'b0}})};
  assign mul_step = {mul_sum, work_reg[WIDTH-1:1]};

  // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
  assign div_shift = {work_reg[2*WIDTH-1:WIDTH], work_reg[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_reg};
  assign div_step  = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                      work_reg[WIDTH-2:0], !div_diff[WIDTH]};

  assign prod_fix = (sign_a_reg ^ sign_b_reg) ? -work_reg : work_reg;
  assign quo_fix  = (sign_a_reg ^ sign_b_reg) ? -work_reg[WIDTH-1:0] : work_reg[WIDTH-1:0];
  assign rem_fix  = sign_a_reg ? -work_reg[2*WIDTH-1:WIDTH] : work_reg[2*WIDTH-1:WIDTH];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (bus.start) state_next = bus.op[1] ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (count_reg == CW'(WIDTH-1)) state_next = S_FIX;
      S_FIX:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= S_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != S_IDLE);
      done_reg  <= (state_reg == S_FIX);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg    <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      work_reg     <= '0;
      opb_reg      <= '0;
      a_orig_reg   <= '0;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      is_div_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            count_reg    <= '0;
            work_reg     <= {{WIDTH{1'b0}}, mag_a};
            opb_reg      <= mag_b;
            a_orig_reg   <= bus.a;
            sign_a_reg   <= sgn_a;
            sign_b_reg   <= sgn_b;
            is_div_reg   <= bus.op[1];
            div_zero_reg <= bus.op[1] && (bus.b == '0);
          end else begin
            if (bus.mthi) hi_reg <= bus.wdata;
            if (bus.mtlo) lo_reg <= bus.wdata;
          end
        end
        S_MUL: begin
          work_reg  <= mul_step;
          count_reg <= count_reg + CW'(1);
        end
        S_DIV: begin
          work_reg  <= div_step;
          count_reg <= count_reg + CW'(1);
        end
        S_FIX: begin
          if (!is_div_reg) begin
            {hi_reg, lo_reg} <= prod_fix;
          end else if (div_zero_reg) begin
            hi_reg <= a_orig_reg;
            lo_reg <= {WIDTH{1'b1}};
          end else begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table of mul/div results plus
// hand sequences for ignored starts/moves, back-to-back ops and async reset.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive start for one edge, then scramble a/b/op to prove they were latched.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    chk("busy_after_start", {31'b0, bus.busy}, 32'd1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    launch(op, a, b);
    wait_done(cyc);
    $display("%s op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h cycles=%0d",
             tag, op, a, b, bus.hi, bus.lo, cyc);
    chk({tag, "_cycles"}, 32'(cyc), 32'd33);
    chk({tag, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
    chk({tag, "_hi"}, bus.hi, ehi);
    chk({tag, "_lo"}, bus.lo, elo);
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{2'b00, 32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9]  = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[10] = '{2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[11] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC};

    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.mthi = 1'b0;  bus.mtlo = 1'b0; bus.wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_clear", i), {31'b0, bus.done}, 32'd0);
    end

    // start + mthi while a MULT is running: both must be ignored
    launch(2'b00, 32'd7, 32'd6);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd1; bus.b = 32'd1;
    bus.mthi = 1'b1;  bus.wdata = 32'h1234;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mthi = 1'b0;
    chk("busy_hi_hold", bus.hi, 32'h00000001);
    wait_done(cyc);
    $display("busy_ignore MULT 7*6 -> hi=0x%08h lo=0x%08h cycles=%0d", bus.hi, bus.lo, cyc + 10);
    chk("busy_ignore_cycles", 32'(cyc + 10), 32'd33);
    chk("busy_ignore_hi", bus.hi, 32'd0);
    chk("busy_ignore_lo", bus.lo, 32'd42);
    @(posedge clk); #1;

    bus.mtlo = 1'b1; bus.wdata = 32'hDEAD;
    @(posedge clk); #1;
    bus.mtlo = 1'b0;
    $display("mtlo wdata=0xDEAD -> hi=0x%08h lo=0x%08h done=%0d", bus.hi, bus.lo, bus.done);
    chk("mtlo_lo", bus.lo, 32'hDEAD);
    chk("mtlo_hi", bus.hi, 32'd0);
    chk("mtlo_done", {31'b0, bus.done}, 32'd0);

    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h5555;
    @(posedge clk); #1;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    $display("mthi+mtlo wdata=0x5555 -> hi=0x%08h lo=0x%08h", bus.hi, bus.lo);
    chk("mtboth_hi", bus.hi, 32'h5555);
    chk("mtboth_lo", bus.lo, 32'h5555);

    // start and mtlo together while idle: start wins
    bus.mtlo = 1'b1; bus.wdata = 32'h9999;
    launch(2'b01, 32'd3, 32'd4);
    bus.mtlo = 1'b0;
    chk("start_wins_lo_hold", bus.lo, 32'h5555);
    wait_done(cyc);
    $display("start+mtlo MULTU 3*4 -> hi=0x%08h lo=0x%08h cycles=%0d", bus.hi, bus.lo, cyc);
    chk("start_wins_hi", bus.hi, 32'd0);
    chk("start_wins_lo", bus.lo, 32'd12);

    // back-to-back: next start issued in the done cycle
    chk("b2b_done_now", {31'b0, bus.done}, 32'd1);
    run_op("b2b", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

    // asynchronous reset in the middle of a DIVU
    launch(2'b11, 32'd100, 32'd7);
    repeat (19) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    $display("async reset mid-DIVU -> busy=%0d done=%0d hi=0x%08h lo=0x%08h",
             bus.busy, bus.done, bus.hi, bus.lo);
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_done", {31'b0, bus.done}, 32'd0);
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("arst_idle_busy", {31'b0, bus.busy}, 32'd0);
    run_op("post_rst", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
